// File: rtl/shifter_pipe_pkg.sv
// Shared definitions for the pipelined log-shifter: operation encodings and mode type.
package shifter_pipe_pkg;

    localparam int unsigned MODE_W = 2;

    typedef enum logic [MODE_W-1:0] {
        SH_LSL = 2'b00,
        SH_LSR = 2'b01,
        SH_ASR = 2'b10,
        SH_ROR = 2'b11
    } sh_mode_e;

endpackage

// File: rtl/shifter_pipe_stage.sv
// One log-shifter stage: conditionally shifts by SHIFT, then registers the operand
// together with its valid, mode and amount so later stages see their own copy.
module shifter_pipe_stage
    import shifter_pipe_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned AMT_W = 5,
    parameter int unsigned SHIFT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             up_valid,
    input  logic [WIDTH-1:0] up_data,
    input  sh_mode_e         up_mode,
    input  logic [AMT_W-1:0] up_amt,
    output logic             ready_c,
    input  logic             dn_ready,
    output logic             dn_valid,
    output logic [WIDTH-1:0] dn_data,
    output sh_mode_e         dn_mode,
    output logic [AMT_W-1:0] dn_amt
);

    localparam int unsigned BIT = $clog2(SHIFT);

    logic [WIDTH-1:0] shifted_c;

    // Single-distance shift; ASR keeps the sign because every earlier stage preserved the MSB.
    always_comb begin
        shifted_c = up_data;
        if (up_amt[BIT]) begin
            case (up_mode)
                SH_LSL:  shifted_c = up_data << SHIFT;
                SH_LSR:  shifted_c = up_data >> SHIFT;
                SH_ASR:  shifted_c = WIDTH'($signed(up_data) >>> SHIFT);
                SH_ROR:  shifted_c = (up_data >> SHIFT) | (up_data << (WIDTH - SHIFT));
                default: shifted_c = up_data;
            endcase
        end
    end

    // Load when empty or when the current content is leaving, so bubbles collapse.
    assign ready_c = !dn_valid || dn_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dn_valid <= 1'b0;
            dn_data  <= '0;
            dn_mode  <= SH_LSL;
            dn_amt   <= '0;
        end else if (ready_c) begin
            dn_valid <= up_valid;
            if (up_valid) begin
                dn_data <= shifted_c;
                dn_mode <= up_mode;
                dn_amt  <= up_amt;
            end
        end
    end

endmodule

// File: rtl/shifter_pipe.sv
// Pipelined barrel shifter (LSL/LSR/ASR/ROR) built from AMT_W registered stages
// with valid/ready flow control and one operand per cycle throughput.
module shifter_pipe
    import shifter_pipe_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned AMT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       sh_mode,
    input  logic [AMT_W-1:0] sh_amt,
    input  logic [WIDTH-1:0] d_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] d_out
);

    logic             stg_valid [AMT_W];
    logic [WIDTH-1:0] stg_data  [AMT_W];
    sh_mode_e         stg_mode  [AMT_W];
    logic [AMT_W-1:0] stg_amt   [AMT_W];
    logic             stg_ready [AMT_W];

    // Stage k shifts by 2^k; its input is the previous stage or the block input.
    for (genvar k = 0; k < AMT_W; k++) begin : g_stage
        logic             up_valid;
        logic [WIDTH-1:0] up_data;
        sh_mode_e         up_mode;
        logic [AMT_W-1:0] up_amt;
        logic             dn_ready;

        if (k == 0) begin : g_head
            assign up_valid = in_valid;
            assign up_data  = d_in;
            assign up_mode  = sh_mode_e'(sh_mode);
            assign up_amt   = sh_amt;
        end else begin : g_body
            assign up_valid = stg_valid[k-1];
            assign up_data  = stg_data[k-1];
            assign up_mode  = stg_mode[k-1];
            assign up_amt   = stg_amt[k-1];
        end

        if (k == AMT_W - 1) begin : g_tail
            assign dn_ready = out_ready;
        end else begin : g_link
            assign dn_ready = stg_ready[k+1];
        end

        shifter_pipe_stage #(
            .WIDTH (WIDTH),
            .AMT_W (AMT_W),
            .SHIFT (2 ** k)
        ) u_stage (
            .clk      (clk),
            .rst      (rst),
            .up_valid (up_valid),
            .up_data  (up_data),
            .up_mode  (up_mode),
            .up_amt   (up_amt),
            .ready_c  (stg_ready[k]),
            .dn_ready (dn_ready),
            .dn_valid (stg_valid[k]),
            .dn_data  (stg_data[k]),
            .dn_mode  (stg_mode[k]),
            .dn_amt   (stg_amt[k])
        );
    end

    assign in_ready  = stg_ready[0];
    assign out_valid = stg_valid[AMT_W-1];
    assign d_out     = stg_data[AMT_W-1];

endmodule

// File: tb/tb_shifter_pipe.sv
// Self-checking bench for shifter_pipe: directed cases on a 32-bit build and
// randomized traffic on 8- and 64-bit builds against a bit-serial reference model.
module tb_shifter_pipe;

    localparam int unsigned W   = 32;
    localparam int unsigned AW  = 5;
    localparam int unsigned W8  = 8;
    localparam int unsigned AW8 = 3;
    localparam int unsigned W64 = 64;
    localparam int unsigned AW64 = 6;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic          in_valid, in_ready, out_valid, out_ready;
    logic [1:0]    sh_mode;
    logic [AW-1:0] sh_amt;
    logic [W-1:0]  d_in, d_out;

    logic           a8_in_valid, a8_in_ready, a8_out_valid, a8_out_ready;
    logic [1:0]     a8_sh_mode;
    logic [AW8-1:0] a8_sh_amt;
    logic [W8-1:0]  a8_d_in, a8_d_out;

    logic            a64_in_valid, a64_in_ready, a64_out_valid, a64_out_ready;
    logic [1:0]      a64_sh_mode;
    logic [AW64-1:0] a64_sh_amt;
    logic [W64-1:0]  a64_d_in, a64_d_out;

    int checks = 0;
    int passes = 0;

    shifter_pipe #(.WIDTH(W)) dut32 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .sh_mode(sh_mode), .sh_amt(sh_amt), .d_in(d_in),
        .out_valid(out_valid), .out_ready(out_ready), .d_out(d_out)
    );

    shifter_pipe #(.WIDTH(W8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(a8_in_valid), .in_ready(a8_in_ready),
        .sh_mode(a8_sh_mode), .sh_amt(a8_sh_amt), .d_in(a8_d_in),
        .out_valid(a8_out_valid), .out_ready(a8_out_ready), .d_out(a8_d_out)
    );

    shifter_pipe #(.WIDTH(W64)) dut64 (
        .clk(clk), .rst(rst), .in_valid(a64_in_valid), .in_ready(a64_in_ready),
        .sh_mode(a64_sh_mode), .sh_amt(a64_sh_amt), .d_in(a64_d_in),
        .out_valid(a64_out_valid), .out_ready(a64_out_ready), .d_out(a64_d_out)
    );

    // Reference: apply the operation one bit position at a time, amt times.
    function automatic logic [63:0] ref_shift(input logic [1:0] mode, input int amt,
                                              input logic [63:0] d, input int w);
        logic [63:0] mask;
        logic [63:0] r;
        logic        msb;
        logic        lsb;
        mask = (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
        r = d & mask;
        for (int i = 0; i < amt; i++) begin
            msb = r[w-1];
            lsb = r[0];
            case (mode)
                2'b00: r = r << 1;
                2'b01: r = r >> 1;
                2'b10: begin r = r >> 1; r[w-1] = msb; end
                default: begin r = r >> 1; r[w-1] = lsb; end
            endcase
            r = r & mask;
        end
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b expected 0", out_valid); else passes++;
        checks++; if (d_out !== '0) $display("FAIL reset_d_out: got %h expected 0", d_out); else passes++;
        checks++; if (a8_out_valid !== 1'b0 || a64_out_valid !== 1'b0)
            $display("FAIL reset_out_valid_w8_w64: got %b/%b expected 0/0", a8_out_valid, a64_out_valid); else passes++;
        rst = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b expected 1", in_ready); else passes++;
        tick();
    endtask

    // Each entry: mode, amount, operand, expected result.
    task automatic test_directed();
        logic [1:0]   tm [8];
        logic [AW-1:0] ta [8];
        logic [W-1:0] td [8];
        logic [W-1:0] te [8];
        int lat;
        tm[0] = 2'b00; ta[0] = 5'd31; td[0] = 32'h0000_0001; te[0] = 32'h8000_0000;
        tm[1] = 2'b10; ta[1] = 5'd4;  td[1] = 32'h8000_0000; te[1] = 32'hF800_0000;
        tm[2] = 2'b01; ta[2] = 5'd4;  td[2] = 32'h8000_0000; te[2] = 32'h0800_0000;
        tm[3] = 2'b11; ta[3] = 5'd4;  td[3] = 32'h0000_00F1; te[3] = 32'h1000_000F;
        for (int i = 4; i < 8; i++) begin
            tm[i] = 2'(i - 4); ta[i] = '0; td[i] = $urandom; te[i] = td[i];
        end
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1; sh_mode = tm[i]; sh_amt = ta[i]; d_in = td[i];
            #1;
            checks++; if (in_ready !== 1'b1) $display("FAIL directed_in_ready[%0d]: got %b expected 1", i, in_ready); else passes++;
            tick();
            in_valid = 1'b0; sh_mode = 2'($urandom); sh_amt = AW'($urandom); d_in = $urandom;
            lat = 1;
            while (!out_valid && lat < 20) begin
                tick();
                lat++;
            end
            checks++; if (lat !== 5) $display("FAIL directed_latency[%0d]: got %0d expected 5", i, lat); else passes++;
            checks++; if (d_out !== te[i]) $display("FAIL directed_value[%0d]: got %h expected %h", i, d_out, te[i]); else passes++;
            tick();
            checks++; if (out_valid !== 1'b0) $display("FAIL directed_single_result[%0d]: got out_valid %b expected 0", i, out_valid); else passes++;
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] exp_q [$];
        logic [W-1:0] held;
        logic [W-1:0] expv;
        logic         stall_prev;
        int sent, got, first_block;
        sent = 0; got = 0; first_block = -1; stall_prev = 1'b0; held = '0;
        for (int cyc = 0; cyc < 60; cyc++) begin
            out_ready = !(cyc >= 3 && cyc <= 10);
            if (sent < 8) begin
                in_valid = 1'b1; sh_mode = 2'($urandom); sh_amt = AW'($urandom); d_in = $urandom;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (stall_prev) begin
                checks++; if (out_valid !== 1'b1 || d_out !== held)
                    $display("FAIL stall_hold: got %b/%h expected 1/%h", out_valid, d_out, held); else passes++;
            end
            stall_prev = out_valid && !out_ready;
            held = d_out;
            if (in_valid && !in_ready && first_block < 0) first_block = sent;
            if (in_valid && in_ready) begin
                exp_q.push_back(W'(ref_shift(sh_mode, int'(sh_amt), 64'(d_in), W)));
                sent++;
            end
            if (out_valid && out_ready) begin
                got++;
                checks++;
                if (exp_q.size() == 0) begin
                    $display("FAIL b2b_extra_result: got %h expected none", d_out);
                end else begin
                    expv = exp_q.pop_front();
                    if (d_out !== expv) $display("FAIL b2b_value: got %h expected %h", d_out, expv); else passes++;
                end
            end
            tick();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        checks++; if (!(first_block >= 0 && first_block <= 5))
            $display("FAIL b2b_accept_before_block: got %0d expected 0..5", first_block); else passes++;
        checks++; if (got !== 8) $display("FAIL b2b_result_count: got %0d expected 8", got); else passes++;
        checks++; if (exp_q.size() !== 0) $display("FAIL b2b_pending: got %0d expected 0", exp_q.size()); else passes++;
    endtask

    task automatic test_reset_midflight();
        logic [W-1:0] expv;
        int seen, lat;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; sh_mode = 2'($urandom); sh_amt = AW'($urandom); d_in = $urandom | 32'h1;
            tick();
        end
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0) $display("FAIL midreset_out_valid: got %b expected 0", out_valid); else passes++;
        checks++; if (d_out !== '0) $display("FAIL midreset_d_out: got %h expected 0", d_out); else passes++;
        tick();
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (out_valid) seen++;
        end
        checks++; if (seen !== 0) $display("FAIL midreset_ghost_results: got %0d expected 0", seen); else passes++;
        in_valid = 1'b1; sh_mode = 2'b01; sh_amt = 5'd3; d_in = $urandom;
        expv = W'(ref_shift(sh_mode, 3, 64'(d_in), W));
        tick();
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        checks++; if (lat !== 5) $display("FAIL midreset_new_latency: got %0d expected 5", lat); else passes++;
        checks++; if (d_out !== expv) $display("FAIL midreset_new_value: got %h expected %h", d_out, expv); else passes++;
        tick();
    endtask

    task automatic test_random_widths();
        logic [W8-1:0]  q8  [$];
        logic [W64-1:0] q64 [$];
        logic [W8-1:0]  e8;
        logic [W64-1:0] e64;
        int got8, got64;
        got8 = 0; got64 = 0;
        for (int cyc = 0; cyc < 430; cyc++) begin
            a8_in_valid   = (cyc < 400) && ($urandom_range(0, 3) != 0);
            a64_in_valid  = (cyc < 400) && ($urandom_range(0, 3) != 0);
            a8_out_ready  = (cyc >= 400) || ($urandom_range(0, 3) != 0);
            a64_out_ready = (cyc >= 400) || ($urandom_range(0, 2) != 0);
            a8_sh_mode  = 2'($urandom); a8_sh_amt  = AW8'($urandom);  a8_d_in  = W8'($urandom);
            a64_sh_mode = 2'($urandom); a64_sh_amt = AW64'($urandom); a64_d_in = {$urandom, $urandom};
            #1;
            if (a8_in_valid && a8_in_ready)
                q8.push_back(W8'(ref_shift(a8_sh_mode, int'(a8_sh_amt), 64'(a8_d_in), W8)));
            if (a64_in_valid && a64_in_ready)
                q64.push_back(ref_shift(a64_sh_mode, int'(a64_sh_amt), a64_d_in, W64));
            if (a8_out_valid && a8_out_ready) begin
                got8++;
                checks++;
                if (q8.size() == 0) begin
                    $display("FAIL w8_extra_result: got %h expected none", a8_d_out);
                end else begin
                    e8 = q8.pop_front();
                    if (a8_d_out !== e8) $display("FAIL w8_value: got %h expected %h", a8_d_out, e8); else passes++;
                end
            end
            if (a64_out_valid && a64_out_ready) begin
                got64++;
                checks++;
                if (q64.size() == 0) begin
                    $display("FAIL w64_extra_result: got %h expected none", a64_d_out);
                end else begin
                    e64 = q64.pop_front();
                    if (a64_d_out !== e64) $display("FAIL w64_value: got %h expected %h", a64_d_out, e64); else passes++;
                end
            end
            tick();
        end
        checks++; if (q8.size() !== 0 || got8 < 100)
            $display("FAIL w8_drain: got pending %0d results %0d expected 0 and >=100", q8.size(), got8); else passes++;
        checks++; if (q64.size() !== 0 || got64 < 100)
            $display("FAIL w64_drain: got pending %0d results %0d expected 0 and >=100", q64.size(), got64); else passes++;
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0; out_ready = 1'b1; sh_mode = '0; sh_amt = '0; d_in = '0;
        a8_in_valid = 1'b0; a8_out_ready = 1'b1; a8_sh_mode = '0; a8_sh_amt = '0; a8_d_in = '0;
        a64_in_valid = 1'b0; a64_out_ready = 1'b1; a64_sh_mode = '0; a64_sh_amt = '0; a64_d_in = '0;
        test_reset();
        test_directed();
        test_back_to_back();
        test_reset_midflight();
        test_random_widths();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
